// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl -- execute-stage sequencer.
//   Single-cycle ALU ops pass straight through to EX/MEM. Mul/div ops fire a
//   one-cycle start pulse to the external unit, hold ID/EX while the unit
//   works, capture its result (sign-extending the low word for RV64 *W ops)
//   and present it with valid/ready toward EX/MEM. A flush aborts with a
//   one-cycle kill pulse to the busy unit.
// Optional feature macro: EXU_PERF_CNT_EN (saturating perf counters; when
//   undefined the perf_* outputs are tied to zero and no counter flops exist).
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   in_valid, in_mul_valid,
//   in_div_valid, in_inst_32        ID/EX outputs
//   flush                           kill current EX instruction
//   out_exu_idle                    0 = hold ID/EX contents
//   mul_start/kill, mul_done/result multiplier handshake
//   div_start/kill, div_done/result divider handshake
//   ex_valid, ex_ready              handshake toward EX/MEM
//   ex_long_sel, ex_long_result     select/capture of mul/div result
//   perf_mul_cyc, perf_div_cyc,
//   perf_hold_cyc                   performance counters
module ex_issue_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_mul_valid,
  input  logic             in_div_valid,
  input  logic             in_inst_32,
  input  logic             flush,
  output logic             out_exu_idle,
  output logic             mul_start,
  output logic             mul_kill,
  input  logic             mul_done,
  input  logic [XLEN-1:0]  mul_result,
  output logic             div_start,
  output logic             div_kill,
  input  logic             div_done,
  input  logic [XLEN-1:0]  div_result,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic             ex_long_sel,
  output logic [XLEN-1:0]  ex_long_result,
  output logic [CNT_W-1:0] perf_mul_cyc,
  output logic [CNT_W-1:0] perf_div_cyc,
  output logic [CNT_W-1:0] perf_hold_cyc
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t            state;
  logic              inst_32_q;
  logic [XLEN-1:0]   long_q;
  logic              req;
  logic              done_hit;
  logic [XLEN-1:0]   done_res;
  logic [XLEN-1:0]   cap_val;

  assign req = in_valid & (in_mul_valid | in_div_valid);

  // Only the done of the unit actually being waited on is honoured.
  always_comb begin
    done_res = (state == MUL_WAIT) ? mul_result : div_result;
    done_hit = ((state == MUL_WAIT) & mul_done) | ((state == DIV_WAIT) & div_done);
    cap_val  = inst_32_q ? {{(XLEN-32){done_res[31]}}, done_res[31:0]} : done_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      inst_32_q <= 1'b0;
      long_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !flush) begin
            inst_32_q <= in_inst_32;
            state     <= in_mul_valid ? MUL_WAIT : DIV_WAIT;
          end
        end
        MUL_WAIT, DIV_WAIT: begin
          // flush beats a same-cycle done: nothing is captured
          if (flush) begin
            state <= IDLE;
          end else if (done_hit) begin
            long_q <= cap_val;
            state  <= DONE;
          end
        end
        DONE: begin
          if (flush || ex_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pulses and handshake are decoded combinationally so starts, kills and
  // ALU pass-through take effect in the same cycle; all are held low while
  // reset is asserted.
  always_comb begin
    out_exu_idle = 1'b0;
    mul_start    = 1'b0;
    mul_kill     = 1'b0;
    div_start    = 1'b0;
    div_kill     = 1'b0;
    ex_valid     = 1'b0;
    ex_long_sel  = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (!req) begin
            ex_valid     = in_valid & ~flush;
            out_exu_idle = 1'b1;
          end else if (flush) begin
            out_exu_idle = 1'b1;
          end else begin
            mul_start = in_mul_valid;
            div_start = ~in_mul_valid;
          end
        end
        MUL_WAIT: mul_kill = flush;
        DIV_WAIT: div_kill = flush;
        DONE: begin
          ex_valid     = ~flush;
          ex_long_sel  = 1'b1;
          out_exu_idle = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ex_long_result = long_q;

`ifdef EXU_PERF_CNT_EN
  logic [CNT_W-1:0] mul_cnt, div_cnt, hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt  <= '0;
      div_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      if (state == MUL_WAIT && mul_cnt != '1) mul_cnt <= mul_cnt + CNT_W'(1);
      if (state == DIV_WAIT && div_cnt != '1) div_cnt <= div_cnt + CNT_W'(1);
      if (state == DONE && !ex_ready && hold_cnt != '1) hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  assign perf_mul_cyc  = mul_cnt;
  assign perf_div_cyc  = div_cnt;
  assign perf_hold_cyc = hold_cnt;
`else
  assign perf_mul_cyc  = '0;
  assign perf_div_cyc  = '0;
  assign perf_hold_cyc = '0;
`endif

endmodule
